// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - branch unit encodings, predictor counter type and update function
//
// Purpose: shared definitions for the branch resolution unit and its
//          branch history table.
// Contents:
//   BR_* : 5-bit brOp encodings produced by the control unit
//   ctr_e : 2-bit saturating predictor counter (SNT/WNT/WT/ST)
//   ctr_next : next counter state for a resolved outcome

package bru_pkg;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_EQ   = 5'b01000;
  localparam logic [4:0] BR_NE   = 5'b01001;
  localparam logic [4:0] BR_LT   = 5'b01100;
  localparam logic [4:0] BR_GE   = 5'b01101;
  localparam logic [4:0] BR_LTU  = 5'b01110;
  localparam logic [4:0] BR_GEU  = 5'b01111;
  localparam logic [4:0] BR_JMP  = 5'b10000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating step toward the resolved direction.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_e'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bru_bht_if.sv
// rtl/bru_bht_if.sv - request/result/lookup bundle for the branch unit
//
// Purpose: groups the resolution request, registered result, prediction
//          lookup and statistics signals of bru_bht.
// Signals:
//   valid_i, pc_i, ru_rs1, ru_rs2, brOp, pred_i : resolution request
//   lookup_pc_i / pred_taken_o                  : fetch-side prediction lookup
//   valid_o, NextPCSrc, mispredict_o            : registered result
//   br_count_o, mispred_count_o                 : statistics
// Modports: master = pipeline side, slave = bru_bht.

interface bru_bht_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);

  logic              valid_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   ru_rs1;
  logic [XLEN-1:0]   ru_rs2;
  logic [4:0]        brOp;
  logic              pred_i;
  logic [XLEN-1:0]   lookup_pc_i;
  logic              pred_taken_o;
  logic              valid_o;
  logic              NextPCSrc;
  logic              mispredict_o;
  logic [STAT_W-1:0] br_count_o;
  logic [STAT_W-1:0] mispred_count_o;

  modport master (
    output valid_i, pc_i, ru_rs1, ru_rs2, brOp, pred_i, lookup_pc_i,
    input  pred_taken_o, valid_o, NextPCSrc, mispredict_o, br_count_o, mispred_count_o
  );

  modport slave (
    input  valid_i, pc_i, ru_rs1, ru_rs2, brOp, pred_i, lookup_pc_i,
    output pred_taken_o, valid_o, NextPCSrc, mispredict_o, br_count_o, mispred_count_o
  );

endinterface

// File: rtl/bru_cmp.sv
// rtl/bru_cmp.sv - combinational branch-taken decode
//
// Purpose: decides whether a branch/jump is taken from brOp and operands.
// Ports:
//   rs1, rs2 : XLEN-bit operands
//   br_op    : 5-bit branch operation
//   taken    : resolved taken flag

module bru_cmp
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      br_op,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    if (br_op[4]) begin
      // any 1xxxx encoding is an unconditional jump
      taken = 1'b1;
    end else begin
      case (br_op)
        BR_EQ:   taken = (rs1 == rs2);
        BR_NE:   taken = (rs1 != rs2);
        BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
        BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
        BR_LTU:  taken = (rs1 <  rs2);
        BR_GEU:  taken = (rs1 >= rs2);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/bru_bht.sv
// rtl/bru_bht.sv - branch resolution unit with 2-bit bimodal history table
//
// Purpose: resolves branches with one cycle latency, flags mispredictions,
//          trains a table of 2-bit counters on conditional branches and
//          serves combinational predictions to fetch.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : bru_bht_if.slave (request, result, lookup, statistics)

module bru_bht
  import bru_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int STAT_W      = 32
) (
  input logic     clk,
  input logic     rst,
  bru_bht_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Flip-flop array so reset can bring every counter to WNT.
  ctr_e tbl [BHT_ENTRIES];

  logic              taken;
  logic              is_cond;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  lk_idx;
  ctr_e              lk_ctr;

  logic              valid_q;
  logic              npc_q;
  logic              mis_q;
  logic [STAT_W-1:0] br_cnt_q;
  logic [STAT_W-1:0] mis_cnt_q;

  // Word-aligned PC bits above the byte offset select the entry.
  assign upd_idx = bus.pc_i[IDX_W+1:2];
  assign lk_idx  = bus.lookup_pc_i[IDX_W+1:2];
  assign is_cond = (bus.brOp[4:3] == 2'b01);

  bru_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1   (bus.ru_rs1),
    .rs2   (bus.ru_rs2),
    .br_op (bus.brOp),
    .taken (taken)
  );

  // Lookup reads the registered table: a same-cycle update is not visible.
  assign lk_ctr           = tbl[lk_idx];
  assign bus.pred_taken_o = lk_ctr[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) tbl[i] <= WNT;
      valid_q   <= 1'b0;
      npc_q     <= 1'b0;
      mis_q     <= 1'b0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q <= bus.valid_i;
      mis_q   <= bus.valid_i && (taken != bus.pred_i);
      if (bus.valid_i) begin
        npc_q <= taken;
        if (is_cond) begin
          tbl[upd_idx] <= ctr_next(tbl[upd_idx], taken);
          if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + STAT_W'(1);
        end
        if ((taken != bus.pred_i) && (mis_cnt_q != '1)) begin
          mis_cnt_q <= mis_cnt_q + STAT_W'(1);
        end
      end
    end
  end

  assign bus.valid_o         = valid_q;
  assign bus.NextPCSrc       = npc_q;
  assign bus.mispredict_o    = mis_q;
  assign bus.br_count_o      = br_cnt_q;
  assign bus.mispred_count_o = mis_cnt_q;

  // PC bits outside the index field do not affect the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_i[XLEN-1:IDX_W+2], bus.pc_i[1:0],
                            bus.lookup_pc_i[XLEN-1:IDX_W+2], bus.lookup_pc_i[1:0]};

endmodule

// File: tb/tb_bru_bht.sv
// tb/tb_bru_bht.sv - directed self-checking bench for bru_bht

module tb_bru_bht;
  import bru_pkg::*;

  localparam int XLEN = 32;
  localparam int BHT  = 16;
  localparam int SW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bru_bht_if #(.XLEN(XLEN), .STAT_W(SW)) bus ();

  bru_bht #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .STAT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [SW-1:0] exp_bc;
  logic [SW-1:0] exp_mc;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] x);
    return (x == '1) ? x : x + SW'(1);
  endfunction

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic p);
    bus.valid_i = v;
    bus.brOp    = op;
    bus.pc_i    = pc;
    bus.ru_rs1  = a;
    bus.ru_rs2  = b;
    bus.pred_i  = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, BR_EQ, 32'h40, 32'd1, 32'd1, 1'b0);
    bus.lookup_pc_i = 32'h0;
    tick();
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid_o got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.NextPCSrc !== 1'b0) begin failures++; $display("FAIL rst_nextpcsrc got=%0h exp=0", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%0h exp=0", bus.mispredict_o); end
    checks++; if (bus.br_count_o !== 4'h0) begin failures++; $display("FAIL rst_br_count got=%0h exp=0", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 4'h0) begin failures++; $display("FAIL rst_mispred_count got=%0h exp=0", bus.mispred_count_o); end
    for (int i = 0; i < BHT; i++) begin
      bus.lookup_pc_i = 32'(i * 4);
      #1;
      checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL rst_pred[%0d] got=%0h exp=0", i, bus.pred_taken_o); end
    end
    drive(1'b0, BR_NONE, 32'h0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    exp_bc = '0;
    exp_mc = '0;
    tick();
  endtask

  task automatic test_beq();
    drive(1'b1, BR_EQ, 32'h104, 32'd10, 32'd10, 1'b0);
    tick();
    exp_bc = sat_inc(exp_bc);
    exp_mc = sat_inc(exp_mc);
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL beq_valid_o got=%0h exp=1", bus.valid_o); end
    checks++; if (bus.NextPCSrc !== 1'b1) begin failures++; $display("FAIL beq_nextpcsrc got=%0h exp=1", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b1) begin failures++; $display("FAIL beq_mispredict got=%0h exp=1", bus.mispredict_o); end
    checks++; if (bus.mispred_count_o !== 4'h1) begin failures++; $display("FAIL beq_mispred_count got=%0h exp=1", bus.mispred_count_o); end
    checks++; if (bus.br_count_o !== 4'h1) begin failures++; $display("FAIL beq_br_count got=%0h exp=1", bus.br_count_o); end
    drive(1'b0, BR_EQ, 32'h104, 32'd1, 32'd2, 1'b1);
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid_o got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.mispredict_o !== 1'b0) begin failures++; $display("FAIL idle_mispredict got=%0h exp=0", bus.mispredict_o); end
    checks++; if (bus.NextPCSrc !== 1'b1) begin failures++; $display("FAIL idle_nextpcsrc_hold got=%0h exp=1", bus.NextPCSrc); end
    checks++; if (bus.br_count_o !== exp_bc) begin failures++; $display("FAIL idle_br_count got=%0h exp=%0h", bus.br_count_o, exp_bc); end
  endtask

  task automatic test_jump();
    bus.lookup_pc_i = 32'h40;
    drive(1'b1, BR_JMP, 32'h40, 32'd0, 32'd0, 1'b1);
    tick();
    checks++; if (bus.NextPCSrc !== 1'b1) begin failures++; $display("FAIL jmp_nextpcsrc got=%0h exp=1", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b0) begin failures++; $display("FAIL jmp_mispredict got=%0h exp=0", bus.mispredict_o); end
    checks++; if (bus.br_count_o !== exp_bc) begin failures++; $display("FAIL jmp_br_count got=%0h exp=%0h", bus.br_count_o, exp_bc); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL jmp_table_unchanged got=%0h exp=0", bus.pred_taken_o); end
    drive(1'b1, 5'b01010, 32'h10C, 32'd3, 32'd3, 1'b0);
    tick();
    exp_bc = sat_inc(exp_bc);
    checks++; if (bus.NextPCSrc !== 1'b0) begin failures++; $display("FAIL undef_nextpcsrc got=%0h exp=0", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b0) begin failures++; $display("FAIL undef_mispredict got=%0h exp=0", bus.mispredict_o); end
    checks++; if (bus.br_count_o !== exp_bc) begin failures++; $display("FAIL undef_br_count got=%0h exp=%0h", bus.br_count_o, exp_bc); end
    drive(1'b1, 5'b00101, 32'h40, 32'd3, 32'd3, 1'b1);
    tick();
    exp_mc = sat_inc(exp_mc);
    checks++; if (bus.NextPCSrc !== 1'b0) begin failures++; $display("FAIL none_nextpcsrc got=%0h exp=0", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b1) begin failures++; $display("FAIL none_mispredict got=%0h exp=1", bus.mispredict_o); end
    checks++; if (bus.mispred_count_o !== exp_mc) begin failures++; $display("FAIL none_mispred_count got=%0h exp=%0h", bus.mispred_count_o, exp_mc); end
    checks++; if (bus.br_count_o !== exp_bc) begin failures++; $display("FAIL none_br_count got=%0h exp=%0h", bus.br_count_o, exp_bc); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL none_table_unchanged got=%0h exp=0", bus.pred_taken_o); end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        p;
    logic        t;
  } vec_t;

  task automatic test_back_to_back();
    vec_t v [8];
    v[0] = '{BR_LT,  32'hFFFF_FFFB, 32'd10,        1'b1, 1'b1};
    v[1] = '{BR_LTU, 32'hFFFF_FFFB, 32'd10,        1'b1, 1'b0};
    v[2] = '{BR_GE,  32'hFFFF_FFFB, 32'd10,        1'b0, 1'b0};
    v[3] = '{BR_GEU, 32'hFFFF_FFFB, 32'd10,        1'b0, 1'b1};
    v[4] = '{BR_NE,  32'd3,         32'd4,         1'b1, 1'b1};
    v[5] = '{BR_EQ,  32'h8000_0000, 32'd0,         1'b0, 1'b0};
    v[6] = '{BR_LT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    v[7] = '{BR_GEU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, v[k].op, 32'h108, v[k].a, v[k].b, v[k].p);
      tick();
      exp_bc = sat_inc(exp_bc);
      if (v[k].t != v[k].p) exp_mc = sat_inc(exp_mc);
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL b2b[%0d]_valid_o got=%0h exp=1", k, bus.valid_o); end
      checks++; if (bus.NextPCSrc !== v[k].t) begin failures++; $display("FAIL b2b[%0d]_nextpcsrc got=%0h exp=%0h", k, bus.NextPCSrc, v[k].t); end
      checks++; if (bus.mispredict_o !== (v[k].t ^ v[k].p)) begin failures++; $display("FAIL b2b[%0d]_mispredict got=%0h exp=%0h", k, bus.mispredict_o, v[k].t ^ v[k].p); end
      checks++; if (bus.br_count_o !== exp_bc) begin failures++; $display("FAIL b2b[%0d]_br_count got=%0h exp=%0h", k, bus.br_count_o, exp_bc); end
      checks++; if (bus.mispred_count_o !== exp_mc) begin failures++; $display("FAIL b2b[%0d]_mispred_count got=%0h exp=%0h", k, bus.mispred_count_o, exp_mc); end
    end
  endtask

  task automatic test_saturation();
    logic exp_pred [5];
    exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.lookup_pc_i = 32'h40;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, BR_EQ, 32'h40, 32'd5, 32'd5, 1'b0);
      else       drive(1'b1, BR_NE, 32'h40, 32'd5, 32'd5, 1'b0);
      tick();
      exp_bc = sat_inc(exp_bc);
      if (k < 3) exp_mc = sat_inc(exp_mc);
      checks++; if (bus.pred_taken_o !== exp_pred[k]) begin failures++; $display("FAIL sat[%0d]_pred got=%0h exp=%0h", k, bus.pred_taken_o, exp_pred[k]); end
    end
    checks++; if (bus.mispred_count_o !== exp_mc) begin failures++; $display("FAIL sat_mispred_count got=%0h exp=%0h", bus.mispred_count_o, exp_mc); end
  endtask

  task automatic test_alias();
    drive(1'b0, BR_NONE, 32'h0, 32'd0, 32'd0, 1'b0);
    bus.lookup_pc_i = 32'h80;
    #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL alias_pre got=%0h exp=0", bus.pred_taken_o); end
    drive(1'b1, BR_EQ, 32'h44, 32'd7, 32'd7, 1'b1);
    tick();
    checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL alias_0x44 got=%0h exp=0", bus.pred_taken_o); end
    drive(1'b1, BR_EQ, 32'h40, 32'd7, 32'd7, 1'b1);
    tick();
    checks++; if (bus.pred_taken_o !== 1'b1) begin failures++; $display("FAIL alias_0x40 got=%0h exp=1", bus.pred_taken_o); end
    bus.lookup_pc_i = 32'h40;
    drive(1'b1, BR_NE, 32'h40, 32'd7, 32'd7, 1'b0);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b1) begin failures++; $display("FAIL alias_no_bypass got=%0h exp=1", bus.pred_taken_o); end
    tick();
    checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL alias_after_update got=%0h exp=0", bus.pred_taken_o); end
  endtask

  task automatic test_stat_sat();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, BR_EQ, 32'h4C, 32'd1, 32'd2, 1'b1);
      tick();
      exp_bc = sat_inc(exp_bc);
      exp_mc = sat_inc(exp_mc);
      checks++; if (bus.mispred_count_o !== exp_mc) begin failures++; $display("FAIL stat[%0d]_mispred_count got=%0h exp=%0h", k, bus.mispred_count_o, exp_mc); end
    end
    checks++; if (bus.mispred_count_o !== 4'hF) begin failures++; $display("FAIL stat_mispred_saturated got=%0h exp=f", bus.mispred_count_o); end
    checks++; if (bus.br_count_o !== 4'hF) begin failures++; $display("FAIL stat_br_saturated got=%0h exp=f", bus.br_count_o); end
  endtask

  task automatic test_reset_mid();
    bus.lookup_pc_i = 32'h40;
    drive(1'b1, BR_EQ, 32'h40, 32'd9, 32'd9, 1'b1);
    tick();
    checks++; if (bus.pred_taken_o !== 1'b1) begin failures++; $display("FAIL mid_pre_pred got=%0h exp=1", bus.pred_taken_o); end
    rst = 1'b1;
    drive(1'b1, BR_EQ, 32'h40, 32'd5, 32'd5, 1'b0);
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL mid_valid_o got=%0h exp=0", bus.valid_o); end
    checks++; if (bus.NextPCSrc !== 1'b0) begin failures++; $display("FAIL mid_nextpcsrc got=%0h exp=0", bus.NextPCSrc); end
    checks++; if (bus.mispredict_o !== 1'b0) begin failures++; $display("FAIL mid_mispredict got=%0h exp=0", bus.mispredict_o); end
    checks++; if (bus.br_count_o !== 4'h0) begin failures++; $display("FAIL mid_br_count got=%0h exp=0", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 4'h0) begin failures++; $display("FAIL mid_mispred_count got=%0h exp=0", bus.mispred_count_o); end
    for (int i = 0; i < BHT; i++) begin
      bus.lookup_pc_i = 32'(i * 4);
      #1;
      checks++; if (bus.pred_taken_o !== 1'b0) begin failures++; $display("FAIL mid_pred[%0d] got=%0h exp=0", i, bus.pred_taken_o); end
    end
    @(negedge clk);
    rst = 1'b0;
    exp_bc = '0;
    exp_mc = '0;
    bus.lookup_pc_i = 32'h40;
    drive(1'b1, BR_EQ, 32'h40, 32'd1, 32'd1, 1'b0);
    tick();
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL post_valid_o got=%0h exp=1", bus.valid_o); end
    checks++; if (bus.mispredict_o !== 1'b1) begin failures++; $display("FAIL post_mispredict got=%0h exp=1", bus.mispredict_o); end
    checks++; if (bus.br_count_o !== 4'h1) begin failures++; $display("FAIL post_br_count got=%0h exp=1", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 4'h1) begin failures++; $display("FAIL post_mispred_count got=%0h exp=1", bus.mispred_count_o); end
    checks++; if (bus.pred_taken_o !== 1'b1) begin failures++; $display("FAIL post_pred got=%0h exp=1", bus.pred_taken_o); end
    drive(1'b0, BR_NONE, 32'h0, 32'd0, 32'd0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_beq();
    test_jump();
    test_back_to_back();
    test_saturation();
    test_alias();
    test_stat_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bru_bht.md
BRU_BHT -- requirements
Module: bru_bht

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width in bits.
REQ-002 Parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters; power of two, at least 2.
REQ-003 Parameter STAT_W, default 32, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  branch/jump resolution request this cycle.
REQ-007 pc_i  input  XLEN  PC of the resolving instruction.
REQ-008 ru_rs1  input  XLEN  register-file value of rs1.
REQ-009 ru_rs2  input  XLEN  register-file value of rs2.
REQ-010 brOp  input  5  branch operation from the control unit.
REQ-011 pred_i  input  1  prediction fetch made for this instruction.
REQ-012 lookup_pc_i  input  XLEN  fetch PC for prediction lookup.
REQ-013 pred_taken_o  output  1  combinational prediction for lookup_pc_i.
REQ-014 valid_o  output  1  registered result valid.
REQ-015 NextPCSrc  output  1  registered resolved taken flag.
REQ-016 mispredict_o  output  1  registered flag: resolved outcome differs from pred_i.
REQ-017 br_count_o  output  STAT_W  resolved conditional branches.
REQ-018 mispred_count_o  output  STAT_W  mispredicted requests of any kind.

Function
REQ-019 Taken decode:
- 00xxx: 0.
- 1xxxx: 1.
- 01000: rs1 == rs2.
- 01001: rs1 != rs2.
- 01100: signed rs1 < rs2.
- 01101: signed rs1 >= rs2.
- 01110: unsigned rs1 < rs2.
- 01111: unsigned rs1 >= rs2.
- 01010 and 01011: 0.
REQ-020 Comparisons use the full XLEN width; signed comparisons are two's complement.
REQ-021 Latency is one cycle: at the edge ending a cycle with valid_i=1, valid_o<=1, NextPCSrc<=taken and mispredict_o<=(taken!=pred_i).
REQ-022 At an edge with valid_i=0: valid_o<=0, mispredict_o<=0, and NextPCSrc holds its previous value.
REQ-023 Table index is pc[log2(BHT_ENTRIES)+1:2] for both lookup and update.
REQ-024 pred_taken_o = MSB of the counter indexed by lookup_pc_i, read combinationally.
REQ-025 Counter update happens only when valid_i=1 and brOp[4:3]=01.
- Taken: saturating increment (11 stays 11).
- Not taken: saturating decrement (00 stays 00).
REQ-026 Counter states: SNT=00, WNT=01, WT=10, ST=11.
REQ-027 A lookup and an update to the same index in the same cycle returns the pre-update value; there is no bypass.
REQ-028 Unconditional jumps (1xxxx) and no-branch (00xxx) never modify the table.
- They still produce valid_o, NextPCSrc and mispredict_o.
REQ-029 br_count_o increments on each valid_i with brOp[4:3]=01.
REQ-030 mispred_count_o increments on each valid_i with taken!=pred_i.
REQ-031 Both statistics counters saturate at all-ones and never wrap.
REQ-032 Inputs are sampled only when valid_i=1; back-to-back requests are accepted every cycle with no stall.

Reset
REQ-033 While rst=1 at an edge, every table counter <= WNT (01).
REQ-034 While rst=1 at an edge, valid_o, NextPCSrc, mispredict_o, br_count_o and mispred_count_o <= 0.
REQ-035 rst has priority over valid_i in the same cycle; that request is discarded and nothing is updated.
REQ-036 After reset, pred_taken_o = 0 for every lookup_pc_i.

Structure
REQ-037 Package bru_pkg holds:
- brOp encodings as localparams (BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JMP).
- the 2-bit counter enum.
- the function computing a counter's next state.
REQ-038 Sub-module bru_cmp holds the combinational taken decode (REQ-019) with parameter XLEN; bru_bht instantiates it once.
REQ-039 The table is a flip-flop array of BHT_ENTRIES x 2 bits, not inferred RAM, so that reset can initialise it.

Verification
REQ-040 Reset, then valid_i=1, brOp=01000, rs1=10, rs2=10, pred_i=0 -> next cycle valid_o=1, NextPCSrc=1, mispredict_o=1, mispred_count_o=1, br_count_o=1.
REQ-041 brOp=01100, rs1=32'hFFFF_FFFB (-5), rs2=10 -> NextPCSrc=1; same operands with brOp=01110 -> NextPCSrc=0.
REQ-042 Predictor saturation at pc_i=lookup_pc_i=0x40 with taken BEQ:
- After 1 update: pred_taken_o=1 (WT).
- After 3 updates: still 1.
- Then 2 not-taken BNE (rs1=rs2): pred_taken_o=1 then 0.
REQ-043 Aliasing with BHT_ENTRIES=16:
- An update at pc 0x40 changes the prediction for 0x80.
- An update at pc 0x44 does not.
- A same-cycle lookup of 0x40 during its update returns the old value.
REQ-044 Unconditional and undefined ops:
- brOp=10000 with pred_i=1 -> NextPCSrc=1, mispredict_o=0, table and br_count_o unchanged.
- brOp=01010 -> NextPCSrc=0.
REQ-045 Reset mid-stream:
- Assert rst together with valid_i=1 -> outputs and counters 0 and all predictions 0 the next cycle.
- Force mispred_count_o to all-ones with STAT_W=4; a further mispredict leaves it at 4'hF.
